// File: rtl/axi_pkg.sv
// Shared AXI encodings and the bridge FSM state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

endpackage

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding bridge: one core load/store becomes one single-beat AXI4
// read or write; completion returns as a one-cycle response pulse.
module axi4_lite_master_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0]  AXI_ID = 4'd0,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [3:0]            awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [3:0]            bid,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [3:0]            arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [1:0]            rresp,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rlast,
  input  logic [3:0]            rid
);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  aw_hs, w_hs;
  logic                  unused_ids;

  // Only one transaction is ever in flight, so response IDs carry no information.
  assign unused_ids = ^{rid, bid};

  // Handshake outputs decode straight from state so an async reset kills them at once.
  assign req_ready = (state_q == IDLE);
  assign arvalid   = (state_q == RD_ADDR);
  assign rready    = (state_q == RD_DATA);
  assign awvalid   = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid    = (state_q == WR_REQ) && !w_done_q;
  assign bready    = (state_q == WR_RESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awsize  = size_q;
  assign arsize  = size_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid;
  assign awid    = AXI_ID;
  assign arid    = AXI_ID;
  assign awlen   = '0;
  assign arlen   = '0;
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = rdata;
          resp_err_d   = (rresp != AXI_RESP_OKAY) || !rlast;
          state_d      = IDLE;
        end
      end
      WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // Leave as soon as the last outstanding channel handshakes, even this cycle.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = (bresp != AXI_RESP_OKAY);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: configurable AXI slave model plus a
// response scoreboard filled at request acceptance.
module tb_axi4_lite_master_bridge;
  import axi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  always #5 clock = ~clock;

  axi4_lite_master_bridge #(.AXI_ID(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .rlast(rlast), .rid(rid)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs
  int unsigned ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic        r_stall = 1'b0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = '0, b_resp = '0;
  logic        r_last = 1'b1;

  initial begin
    int unsigned ar_cnt, aw_cnt, w_cnt;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = '0; rlast = 0; bresp = '0; rid = 4'hA; bid = 4'h3;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (arvalid) begin
          arready = (ar_cnt >= ar_delay);
          if (!arready) ar_cnt++;
        end else begin arready = 0; ar_cnt = 0; end
        if (awvalid) begin
          awready = (aw_cnt >= aw_delay);
          if (!awready) aw_cnt++;
        end else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin
          wready = (w_cnt >= w_delay);
          if (!wready) w_cnt++;
        end else begin wready = 0; w_cnt = 0; end
        rvalid = rready && !rvalid && !r_stall;
        rdata = r_data; rresp = r_resp; rlast = r_last;
        bvalid = bready && !bvalid;
        bresp = b_resp;
      end
    end
  end

  // Scoreboard and bus monitor
  logic [32:0] sb[$];
  logic [32:0] e;
  logic [31:0] exp_addr, exp_wdata;
  logic [2:0]  exp_size;
  logic [3:0]  exp_wstrb;
  int unsigned cyc = 0, accept_cyc = 0, resp_cyc = 0, resp_seen = 0;
  int unsigned ar_hi = 0, aw_hi = 0, w_hi = 0, b_hi = 0, overlap = 0;

  always begin
    @(negedge clock);
    #2;
    cyc++;
    if (reset) begin
      if (req_valid && req_ready) begin
        if (req_we) sb.push_back({32'h0, b_resp != AXI_RESP_OKAY});
        else        sb.push_back({r_data, (r_resp != AXI_RESP_OKAY) || !r_last});
        exp_addr = req_addr; exp_size = req_size;
        exp_wdata = req_wdata; exp_wstrb = req_wstrb;
        accept_cyc = cyc;
      end
      if (resp_valid) begin
        resp_seen++;
        resp_cyc = cyc;
        if (sb.size() == 0) check_eq("resp_unexpected", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check_eq("resp_rdata", {32'h0, resp_rdata}, {32'h0, e[32:1]});
          check_eq("resp_err", {63'h0, resp_err}, {63'h0, e[0]});
        end
      end
      if (arvalid) ar_hi++;
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (bready)  b_hi++;
      if ((arvalid || rready) && (awvalid || wvalid || bready)) overlap++;
      if (arvalid && arready) begin
        check_eq("araddr", {32'h0, araddr}, {32'h0, exp_addr});
        check_eq("arsize", {61'h0, arsize}, {61'h0, exp_size});
      end
      if (awvalid && awready) begin
        check_eq("awaddr", {32'h0, awaddr}, {32'h0, exp_addr});
        check_eq("awsize", {61'h0, awsize}, {61'h0, exp_size});
      end
      if (wvalid && wready) begin
        check_eq("wdata", {32'h0, wdata}, {32'h0, exp_wdata});
        check_eq("wstrb", {60'h0, wstrb}, {60'h0, exp_wstrb});
        check_eq("wlast", {63'h0, wlast}, 64'd1);
      end
    end
  end

  task automatic clear_counts();
    ar_hi = 0; aw_hi = 0; w_hi = 0; b_hi = 0;
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (req_ready) got = 1;
    end
    if (!got) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] data, input logic [3:0] strb);
    @(posedge clock); #1;
    req_we = we; req_addr = addr; req_size = size; req_wdata = data; req_wstrb = strb;
    req_valid = 1;
    wait_accept();
    @(posedge clock); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(input int unsigned start);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock); #3;
      if (resp_seen > start) got = 1;
    end
    if (!got) check_eq("resp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int unsigned n;
    req_valid = 0; req_we = 0; req_addr = '0; req_size = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_outputs", {56'h0, arvalid, awvalid, wvalid, bready, rready, resp_valid, resp_err, req_ready}, 64'h01);
    check_eq("rst_rdata", {32'h0, resp_rdata}, 64'h0);
    check_eq("rst_addr", {awaddr, araddr}, 64'h0);
    check_eq("const_len", {48'h0, awlen, arlen}, 64'h0);
    check_eq("const_burst_id", {52'h0, awburst, arburst, awid ^ arid}, {52'h0, AXI_BURST_INCR, AXI_BURST_INCR, 4'h0});
    @(negedge clock); reset = 1;

    // Simple read, 3-cycle latency
    r_data = 32'hDEADBEEF; r_resp = AXI_RESP_OKAY; r_last = 1;
    clear_counts(); n = resp_seen;
    do_req(0, 32'h0000_0100, SZ_W, '0, '0);
    wait_resp(n);
    check_eq("rd_arvalid_cycles", 64'(ar_hi), 64'd1);
    check_eq("rd_latency", 64'(resp_cyc - accept_cyc), 64'd3);
    repeat (3) @(negedge clock);
    check_eq("rd_single_pulse", 64'(resp_seen), 64'(n + 1));

    // Write, awready delayed 3 cycles
    aw_delay = 3; w_delay = 0; b_resp = AXI_RESP_OKAY;
    clear_counts(); n = resp_seen;
    do_req(1, 32'h8000_0010, SZ_W, 32'h1234_5678, 4'b0011);
    wait_resp(n);
    check_eq("wr_wvalid_cycles", 64'(w_hi), 64'd1);
    check_eq("wr_awvalid_cycles", 64'(aw_hi), 64'd4);
    check_eq("wr_bready_cycles", 64'(b_hi), 64'd1);

    // Write, wready delayed, SLVERR
    aw_delay = 0; w_delay = 2; b_resp = AXI_RESP_SLVERR;
    clear_counts(); n = resp_seen;
    do_req(1, 32'h0000_0044, SZ_H, 32'h0000_BEEF, 4'b1100);
    wait_resp(n);
    check_eq("wr2_awvalid_cycles", 64'(aw_hi), 64'd1);
    check_eq("wr2_wvalid_cycles", 64'(w_hi), 64'd3);

    // Fast write latency
    w_delay = 0; b_resp = AXI_RESP_OKAY; n = resp_seen;
    do_req(1, 32'h0000_0008, SZ_B, 32'h0000_00AB, 4'b0001);
    wait_resp(n);
    check_eq("wr_latency", 64'(resp_cyc - accept_cyc), 64'd3);

    // Read error cases
    r_resp = AXI_RESP_SLVERR; r_data = 32'h1111_2222; n = resp_seen;
    do_req(0, 32'h0000_0200, SZ_W, '0, '0);
    wait_resp(n);
    r_resp = AXI_RESP_OKAY; r_last = 0; r_data = 32'h3333_4444; n = resp_seen;
    do_req(0, 32'h0000_0204, SZ_W, '0, '0);
    wait_resp(n);
    r_last = 1;

    // Back-to-back read then write with req_valid held
    r_data = 32'hCAFE_F00D; overlap = 0; n = resp_seen;
    @(posedge clock); #1;
    req_we = 0; req_addr = 32'h0000_0300; req_size = SZ_W; req_valid = 1;
    wait_accept();
    @(posedge clock); #1;
    req_we = 1; req_addr = 32'h0000_0020; req_wdata = 32'hA5A5_A5A5; req_wstrb = 4'hF;
    wait_accept();
    check_eq("b2b_accept_on_resp", {63'h0, resp_valid}, 64'd1);
    @(posedge clock); #1;
    req_valid = 0;
    wait_resp(n + 1);
    check_eq("b2b_no_overlap", 64'(overlap), 64'd0);

    // Reset while in RD_DATA
    r_stall = 1; n = resp_seen;
    do_req(0, 32'h0000_0400, SZ_W, '0, '0);
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clock);
        if (rready) got = 1;
      end
      if (!got) check_eq("rst_mid_reach_rd_data", 64'd0, 64'd1);
    end
    #1 reset = 0;
    #1;
    check_eq("rst_mid_handshakes", {61'h0, rready, arvalid, resp_valid}, 64'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock); #1 reset = 1; r_stall = 0;
    repeat (4) @(negedge clock);
    check_eq("rst_mid_no_resp", 64'(resp_seen), 64'(n));
    check_eq("rst_mid_req_ready", {63'h0, req_ready}, 64'd1);

    // arready held off while req_valid toggles
    ar_delay = 10; r_data = 32'h5555_AAAA; clear_counts(); n = resp_seen;
    do_req(0, 32'h4444_0000, SZ_H, '0, '0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      req_valid = (i % 2 == 0); req_we = 0; req_addr = $urandom;
      @(negedge clock);
      check_eq("stall_arvalid", {63'h0, arvalid}, 64'd1);
      check_eq("stall_araddr", {32'h0, araddr}, 64'h4444_0000);
      check_eq("stall_req_ready", {63'h0, req_ready}, 64'd0);
    end
    req_valid = 0;
    wait_resp(n);
    check_eq("stall_arvalid_cycles", 64'(ar_hi), 64'd11);
    ar_delay = 0;

    repeat (5) @(negedge clock);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master_bridge.md
Name: axi4_lite_master_bridge

Overview:
- Single-outstanding AXI4 master. Converts a simple core-side load/store request into one single-beat AXI4 read or write transaction.
- Sits between the LSU/IFU arbiter and the memory-side AXI4 slaves (SRAM, UART, CLINT).
- Returns read data or write completion to the core as a one-cycle response pulse.

Parameters:
- AXI_ID, 4'd0, value driven on arid and awid.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (bus is fixed at 4 byte lanes; only 32 is supported).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_size  in  3  AXI size code (0 = byte, 1 = half, 2 = word).
- req_wdata  in  32  write data, already lane-aligned.
- req_wstrb  in  4  write byte strobes.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  read data; 0 for writes.
- resp_err  out  1  error flag for the transaction.
- AXI AW channel: awvalid out 1, awready in 1, awaddr out 32, awid out 4, awlen out 8, awsize out 3, awburst out 2.
- AXI W channel: wvalid out 1, wready in 1, wdata out 32, wstrb out 4, wlast out 1.
- AXI B channel: bvalid in 1, bready out 1, bresp in 2, bid in 4.
- AXI AR channel: arvalid out 1, arready in 1, araddr out 32, arid out 4, arlen out 8, arsize out 3, arburst out 2.
- AXI R channel: rvalid in 1, rready out 1, rresp in 2, rdata in 32, rlast in 1, rid in 4.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err are 0.
  - resp_rdata and all latched request registers are 0.
- Constant outputs: awlen = arlen = 0, awburst = arburst = 2'b01, wlast = wvalid, awid = arid = AXI_ID.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- req_ready = (state == IDLE). A request is accepted on a cycle where req_valid & req_ready; addr, size, wdata, wstrb and we are latched on that edge.
- IDLE:
  - Accepted read -> RD_ADDR, arvalid = 1 from the next cycle.
  - Accepted write -> WR_REQ, awvalid = wvalid = 1 from the next cycle.
- RD_ADDR:
  - araddr and arsize are driven from the latched request.
  - arvalid is held until arready is sampled high; it never drops before that handshake.
  - On handshake: arvalid = 0, rready = 1, go to RD_DATA.
- RD_DATA:
  - On rvalid & rready: rready = 0, latch rdata into resp_rdata, resp_err = (rresp != 0) | ~rlast, resp_valid = 1 for the next cycle only, go to IDLE.
- WR_REQ:
  - awvalid and wvalid are independent. Each drops on the edge after its own handshake, and completion is tracked with aw_done and w_done flags.
  - Both handshakes in the same cycle is legal.
  - When both are done (including the case where the final one completes this cycle): bready = 1, go to WR_RESP.
- WR_RESP:
  - On bvalid & bready: bready = 0, resp_err = (bresp != 0), resp_rdata = 0, resp_valid = 1 for one cycle, go to IDLE.
- Latency: with an always-ready slave that responds one cycle after the address handshake, a read takes 3 cycles from req accept to resp_valid. A write takes 3 cycles with the same slave.
- Back-to-back: req_ready is high in the same cycle resp_valid pulses, so the next request can be accepted then.
- The response has no backpressure; the consumer must take resp_valid when it pulses.
- rid and bid are ignored because only one transaction is outstanding.
- Reset mid-transaction: all valid and ready outputs drop immediately and the transaction is abandoned. No response is issued.

Decomposition:
- Package axi_pkg holds:
  - AXI_BURST_INCR = 2'b01.
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
  - Size codes SZ_B = 0, SZ_H = 1, SZ_W = 2.
  - A state enum typedef.
- No sub-module. The single FSM plus the aw_done/w_done flags are sufficient.

Test Plan:
- Read, slave with arready = 1 and rvalid one cycle later, rdata = 32'hDEADBEEF, rresp = 0, rlast = 1 -> one resp_valid pulse, resp_rdata = 32'hDEADBEEF, resp_err = 0, arvalid high exactly 1 cycle.
- Write to 32'h8000_0010, wdata = 32'h1234_5678, wstrb = 4'b0011; slave delays awready 3 cycles and wready 0 cycles -> wvalid drops after 1 cycle, awvalid stays high 4 cycles, then bready = 1; bresp = 0 gives resp_valid with resp_err = 0.
- Read with rresp = 2'b10 -> resp_err = 1. Repeat with rresp = 0 and rlast = 0 -> resp_err = 1.
- Back-to-back read then write with req_valid held high -> second request accepted in the same cycle as the first resp_valid; no cycle where two AXI valids from different transactions overlap.
- Assert reset low while in RD_DATA with rready = 1 -> rready = 0 within the same cycle, no resp_valid; after release, req_ready = 1.
- Slave holds arready = 0 for 10 cycles while req_valid toggles -> arvalid stable at 1, araddr unchanged, req_ready = 0 throughout.
